sargantana_set_ram_ctrl: RTL and testbench
==========================================

// Module: sargantana_set_ram_ctrl
// PURPOSE
//  Initiator for one sargantana_set_ram instance. The RAM has one port: req/we/addr/data, and
//  read data is valid one cycle after a read request.
//  This block multiplexes three RAM users onto that port: fetch lookups (reads), line refills
//  (beats assembled into a full set line and then written), and a flush sweep that zeroes
//  every entry. It sits between the icache control FSM / refill path and the set RAM.
// PARAMETERS
//  ICACHE_DEPTH  64    number of RAM entries; flush sweep length
//  SET_WIDHT     256   RAM line width, bits
//  ADDR_WIDHT    6     RAM address width; ICACHE_DEPTH <= 2**ADDR_WIDHT
//  BEAT_WIDTH    64    refill beat width; SET_WIDHT % BEAT_WIDTH == 0; BEATS = SET_WIDHT/BEAT_WIDTH
// PORTS
//  clk_i           in   1           clock, all state updates on rising edge
//  rst_i           in   1           synchronous reset, active-high
//  lookup_req_i    in   1           read request
//  lookup_addr_i   in   ADDR_WIDHT  read address
//  lookup_ready_o  out  1           lookup accepted this cycle when req & ready
//  lookup_valid_o  out  1           lookup_data_o valid (1 cycle after accept)
//  lookup_data_o   out  SET_WIDHT   read line (= ram_data_i)
//  refill_start_i  in   1           begin refill of refill_addr_i (sampled in IDLE only)
//  refill_addr_i   in   ADDR_WIDHT  refill target index
//  beat_valid_i    in   1           refill beat present
//  beat_data_i     in   BEAT_WIDTH  refill beat payload
//  beat_ready_o    out  1           beat accepted when valid & ready
//  refill_done_o   out  1           1-cycle pulse: line written to RAM
//  flush_i         in   1           level request to zero the whole RAM
//  flush_busy_o    out  1           high while sweep is in progress
//  ram_req_o       out  1           to RAM req_i
//  ram_we_o        out  1           to RAM we_i
//  ram_addr_o      out  ADDR_WIDHT  to RAM addr_i
//  ram_data_o      out  SET_WIDHT   to RAM data_i
//  ram_data_i      in   SET_WIDHT   from RAM data_o
// BEHAVIOUR
//  Reset: state=IDLE; beat count, flush count, assembled line, and registered outputs cleared.
//    While rst_i=1, every output is 0, including the combinational RAM and ready outputs.
//    Reset mid-FILL/FLUSH aborts the operation; no further RAM write is issued.
//  FSM states: IDLE, FILL, WRITE, FLUSH.
//  Port priority each cycle: FLUSH sweep or WRITE > lookup. Only one RAM request per cycle.
//  IDLE:
//    - flush_i -> FLUSH, with flush count = 0.
//    - else refill_start_i -> FILL: latch refill_addr_i; beat count = 0.
//  FILL:
//    - beat_ready_o=1. Beat k is stored at line[k*BEAT_WIDTH +: BEAT_WIDTH].
//    - Accepting beat BEATS-1 -> WRITE.
//    - flush_i in FILL: discard the partial line -> FLUSH; no RAM write occurs.
//  WRITE (exactly 1 cycle):
//    - ram_req_o=1, ram_we_o=1, ram_addr_o=latched addr, ram_data_o=line.
//    - Next cycle: refill_done_o=1 (registered).
//    - Next state: FLUSH if flush_i else IDLE. refill_start_i is ignored here.
//  FLUSH:
//    - Each cycle: req=1, we=1, addr=flush count, data=0; count increments.
//    - After the write to ICACHE_DEPTH-1 -> IDLE.
//    - flush_busy_o=1 for exactly ICACHE_DEPTH cycles.
//    - flush_i and refill_start_i are ignored while in FLUSH.
//  Lookup:
//    - lookup_ready_o = (state==IDLE | state==FILL) & !flush_i.
//    - On accept: req=1, we=0, addr=lookup_addr_i.
//    - lookup_valid_o registered: 1 in the cycle after accept, else 0.
//    - lookup_data_o = ram_data_i (no extra register).
//    - Lookups are accepted during FILL; beats and reads proceed in parallel.
//    - A lookup to the refill index during FILL returns the old contents.
//  Idle RAM outputs: ram_req_o=0; ram_we_o, ram_addr_o, ram_data_o = 0.
//  Counters: beat count is clog2(BEATS) wide and wraps to 0 on the WRITE transition.
//    Flush count is ADDR_WIDHT wide.
// TESTING
//  1 Reset then lookup addr 5 (RAM preloaded 5:=A) -> valid=1 one cycle later, data=A; no we pulse.
//  2 Refill addr 9, beats 0x11,0x22,0x33,0x44 (one per cycle) -> one write to addr 9,
//    line=0x44_33_22_11 (beat0 LSB), then refill_done 1 cycle; lookup 9 returns that line.
//  3 Beats with gaps (valid toggling), lookups to addr 3 interleaved in FILL -> both lookup
//    data and the final line are correct.
//  4 Flush during 2nd beat -> no write to the refill addr; 64 zero writes to 0..63.
//    flush_busy high 64 cycles; lookup_ready=0 throughout; all lookups then return 0.
//  5 refill_start with flush_i same cycle in IDLE -> flush wins, refill ignored.
//    flush_i asserted in WRITE -> write completes, then FLUSH.
//  6 rst_i pulsed mid-FILL and mid-FLUSH -> outputs 0 during reset; IDLE after;
//    no write and no refill_done.

Source files
------------

// File: rtl/sargantana_set_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// sargantana_set_ram_ctrl_if
// Bundles every non-clock signal of sargantana_set_ram_ctrl:
//   lookup_*  : fetch read requests and their returned line
//   refill_*  : refill start/target index and completion pulse
//   beat_*    : refill beat stream (valid/ready handshake)
//   flush_*   : whole-RAM zeroing request and busy indication
//   ram_*     : the single set-RAM port driven by the controller
// Modports:
//   slave  - the controller itself
//   master - the environment (icache FSM, refill path and set RAM)
// ----------------------------------------------------------------------------
interface sargantana_set_ram_ctrl_if #(
    parameter int ADDR_WIDHT = 6,
    parameter int SET_WIDHT  = 256,
    parameter int BEAT_WIDTH = 64
);
    logic                  lookup_req_i;
    logic [ADDR_WIDHT-1:0] lookup_addr_i;
    logic                  lookup_ready_o;
    logic                  lookup_valid_o;
    logic [SET_WIDHT-1:0]  lookup_data_o;

    logic                  refill_start_i;
    logic [ADDR_WIDHT-1:0] refill_addr_i;
    logic                  beat_valid_i;
    logic [BEAT_WIDTH-1:0] beat_data_i;
    logic                  beat_ready_o;
    logic                  refill_done_o;

    logic                  flush_i;
    logic                  flush_busy_o;

    logic                  ram_req_o;
    logic                  ram_we_o;
    logic [ADDR_WIDHT-1:0] ram_addr_o;
    logic [SET_WIDHT-1:0]  ram_data_o;
    logic [SET_WIDHT-1:0]  ram_data_i;

    modport slave (
        input  lookup_req_i, lookup_addr_i,
        output lookup_ready_o, lookup_valid_o, lookup_data_o,
        input  refill_start_i, refill_addr_i, beat_valid_i, beat_data_i,
        output beat_ready_o, refill_done_o,
        input  flush_i,
        output flush_busy_o,
        output ram_req_o, ram_we_o, ram_addr_o, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output lookup_req_i, lookup_addr_i,
        input  lookup_ready_o, lookup_valid_o, lookup_data_o,
        output refill_start_i, refill_addr_i, beat_valid_i, beat_data_i,
        input  beat_ready_o, refill_done_o,
        output flush_i,
        input  flush_busy_o,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_data_o,
        output ram_data_i
    );
endinterface

// File: rtl/sargantana_set_ram_ctrl.sv
// ----------------------------------------------------------------------------
// sargantana_set_ram_ctrl
// Initiator for one single-port sargantana_set_ram (read data one cycle after
// the request). Three users share the port:
//   - fetch lookups (reads), accepted in IDLE and FILL
//   - refills: BEATS beats are assembled into a line, then written in WRITE
//   - flush: a sweep writing zero to every entry 0..ICACHE_DEPTH-1
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous active-high reset; forces every output to 0
//   bus    : sargantana_set_ram_ctrl_if.slave (lookup / refill / beat /
//            flush / ram signal groups)
// ----------------------------------------------------------------------------
module sargantana_set_ram_ctrl #(
    parameter int ICACHE_DEPTH = 64,
    parameter int SET_WIDHT    = 256,
    parameter int ADDR_WIDHT   = 6,
    parameter int BEAT_WIDTH   = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    sargantana_set_ram_ctrl_if.slave       bus
);

    localparam int BEATS = SET_WIDHT / BEAT_WIDTH;
    // Keep the beat counter at least one bit wide so single-beat lines still elaborate.
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0]        LAST_BEAT  = BCW'(BEATS - 1);
    localparam logic [ADDR_WIDHT-1:0] LAST_ENTRY = ADDR_WIDHT'(ICACHE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [BCW-1:0]        beat_cnt_reg;
    logic [ADDR_WIDHT-1:0] flush_cnt_reg;
    logic [ADDR_WIDHT-1:0] refill_addr_reg;
    logic                  lookup_valid_reg;
    logic                  refill_done_reg;
    logic [SET_WIDHT-1:0]  line;

    logic lookup_ready;
    logic lookup_accept;
    logic beat_accept;

    // Handshake qualifiers. Gating with rst_i keeps every output low while the
    // reset is held, even in the first reset cycle before the registers clear.
    assign lookup_ready  = !rst_i && ((state_reg == IDLE) || (state_reg == FILL)) && !bus.flush_i;
    assign lookup_accept = bus.lookup_req_i && lookup_ready;
    assign beat_accept   = !rst_i && (state_reg == FILL) && bus.beat_valid_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // Flush has priority over a refill started in the same cycle.
                if (bus.flush_i) begin
                    state_next = FLUSH;
                end else if (bus.refill_start_i) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                // A flush abandons the partially assembled line; it is never written.
                if (bus.flush_i) begin
                    state_next = FLUSH;
                end else if (beat_accept && (beat_cnt_reg == LAST_BEAT)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = bus.flush_i ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (flush_cnt_reg == LAST_ENTRY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (RAM port arbitration and ready signals)
    // ------------------------------------------------------------------
    always_comb begin
        bus.ram_req_o      = 1'b0;
        bus.ram_we_o       = 1'b0;
        bus.ram_addr_o     = '0;
        bus.ram_data_o     = '0;
        bus.beat_ready_o   = 1'b0;
        bus.flush_busy_o   = 1'b0;
        bus.lookup_ready_o = lookup_ready;
        if (!rst_i) begin
            bus.beat_ready_o = (state_reg == FILL);
            bus.flush_busy_o = (state_reg == FLUSH);
            case (state_reg)
                WRITE: begin
                    bus.ram_req_o  = 1'b1;
                    bus.ram_we_o   = 1'b1;
                    bus.ram_addr_o = refill_addr_reg;
                    bus.ram_data_o = line;
                end
                FLUSH: begin
                    // Data stays at the zero default.
                    bus.ram_req_o  = 1'b1;
                    bus.ram_we_o   = 1'b1;
                    bus.ram_addr_o = flush_cnt_reg;
                end
                default: begin
                    // lookup_ready already excludes WRITE/FLUSH, so the lookup
                    // can only reach the port when nothing else owns it.
                    if (lookup_accept) begin
                        bus.ram_req_o  = 1'b1;
                        bus.ram_addr_o = bus.lookup_addr_i;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, latched refill index and registered status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_reg     <= '0;
            flush_cnt_reg    <= '0;
            refill_addr_reg  <= '0;
            lookup_valid_reg <= 1'b0;
            refill_done_reg  <= 1'b0;
        end else begin
            lookup_valid_reg <= lookup_accept;
            refill_done_reg  <= (state_reg == WRITE);
            case (state_reg)
                IDLE: begin
                    if (bus.flush_i) begin
                        flush_cnt_reg <= '0;
                    end else if (bus.refill_start_i) begin
                        refill_addr_reg <= bus.refill_addr_i;
                        beat_cnt_reg    <= '0;
                    end
                end
                FILL: begin
                    if (bus.flush_i) begin
                        flush_cnt_reg <= '0;
                    end else if (beat_accept) begin
                        // Explicit wrap so non-power-of-two beat counts still return to 0.
                        beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0
                                                                    : beat_cnt_reg + BCW'(1);
                    end
                end
                WRITE: begin
                    if (bus.flush_i) begin
                        flush_cnt_reg <= '0;
                    end
                end
                FLUSH: begin
                    flush_cnt_reg <= flush_cnt_reg + ADDR_WIDHT'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line assembly: one register per beat slot, beat k lands in slice k
    // (beat 0 in the least significant bits).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : gen_slot
            logic [BEAT_WIDTH-1:0] slot_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    slot_reg <= '0;
                end else if (beat_accept && !bus.flush_i && (beat_cnt_reg == BCW'(gi))) begin
                    slot_reg <= bus.beat_data_i;
                end
            end

            assign line[gi*BEAT_WIDTH +: BEAT_WIDTH] = slot_reg;
        end
    endgenerate

    // Registered pulses and pass-through read data, all forced low in reset.
    assign bus.lookup_valid_o = lookup_valid_reg && !rst_i;
    assign bus.refill_done_o  = refill_done_reg && !rst_i;
    assign bus.lookup_data_o  = rst_i ? '0 : bus.ram_data_i;

endmodule

// File: tb/tb_sargantana_set_ram_ctrl.sv
module tb_sargantana_set_ram_ctrl;

    localparam int AW    = 6;
    localparam int SW    = 256;
    localparam int BW    = 64;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    sargantana_set_ram_ctrl_if #(.ADDR_WIDHT(AW), .SET_WIDHT(SW), .BEAT_WIDTH(BW)) bus ();

    sargantana_set_ram_ctrl #(
        .ICACHE_DEPTH(DEPTH), .SET_WIDHT(SW), .ADDR_WIDHT(AW), .BEAT_WIDTH(BW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural set RAM: registered read, write log for checking.
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] rdata;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [SW-1:0] pre_data = '0;
    int            wr_total = 0;
    int            wr_to [DEPTH] = '{default: 0};

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.ram_req_o) begin
            if (bus.ram_we_o) begin
                mem[bus.ram_addr_o]   <= bus.ram_data_o;
                wr_total              <= wr_total + 1;
                wr_to[bus.ram_addr_o] <= wr_to[bus.ram_addr_o] + 1;
            end else begin
                rdata <= mem[bus.ram_addr_o];
            end
        end
    end
    assign bus.ram_data_i = rdata;

    localparam logic [SW-1:0] LINE_A = {64'hAAAA_0000_0000_0005, 64'h0, 64'h0, 64'h1234};
    localparam logic [SW-1:0] LINE_B = {64'hBBBB, 64'h3, 64'hB3B3, 64'h0BAD_F00D};
    localparam logic [SW-1:0] LINE_C = {64'hC0DE, 64'hCC, 64'h12, 64'h0C0C_0C0C};
    localparam logic [SW-1:0] LINE_D = {64'hDDDD, 64'hDD, 64'hD, 64'h1};

    task automatic drive_idle();
        bus.lookup_req_i   = 1'b0;
        bus.lookup_addr_i  = '0;
        bus.refill_start_i = 1'b0;
        bus.refill_addr_i  = '0;
        bus.beat_valid_i   = 1'b0;
        bus.beat_data_i    = '0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [SW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    function automatic logic outs_any();
        return |{bus.lookup_ready_o, bus.lookup_valid_o, bus.beat_ready_o, bus.refill_done_o,
                 bus.flush_busy_o, bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o,
                 bus.ram_data_o, bus.lookup_data_o};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        bus.lookup_req_i = 1'b1; bus.flush_i = 1'b1; bus.refill_start_i = 1'b1; bus.beat_valid_i = 1'b1;
        #1;
        checks++;
        if (outs_any() !== 1'b0) $display("FAIL reset_outputs: some output nonzero under reset, want all 0");
        else passes++;
        @(negedge clk);
        drive_idle();
        preload(6'd5, LINE_A);
        preload(6'd3, LINE_B);
        preload(6'd12, LINE_C);
        preload(6'd20, LINE_D);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.lookup_ready_o, bus.flush_busy_o, bus.beat_ready_o, bus.ram_req_o} !== 4'b1000)
            $display("FAIL reset_idle: ready/busy/beat_ready/req=%b want 1000",
                     {bus.lookup_ready_o, bus.flush_busy_o, bus.beat_ready_o, bus.ram_req_o});
        else passes++;
    endtask

    task automatic test_lookup();
        int w0;
        w0 = wr_total;
        @(negedge clk);
        bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 6'd5;
        #1;
        checks++;
        if ({bus.lookup_ready_o, bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o} !== {3'b110, 6'd5})
            $display("FAIL lookup_issue: ready/req/we/addr=%b/%b/%b/%0d want 1/1/0/5",
                     bus.lookup_ready_o, bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o);
        else passes++;
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        checks++;
        if (bus.lookup_valid_o !== 1'b1 || bus.lookup_data_o !== LINE_A)
            $display("FAIL lookup_data: valid=%b data=%h want 1 %h", bus.lookup_valid_o, bus.lookup_data_o, LINE_A);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.lookup_valid_o !== 1'b0 || wr_total !== w0)
            $display("FAIL lookup_after: valid=%b writes=%0d want 0 %0d", bus.lookup_valid_o, wr_total, w0);
        else passes++;
    endtask

    task automatic test_refill();
        logic [BW-1:0] beats [4];
        logic [SW-1:0] exp_line;
        int w9;
        beats = '{64'h11, 64'h22, 64'h33, 64'h44};
        exp_line = {64'h44, 64'h33, 64'h22, 64'h11};
        w9 = wr_to[9];
        @(negedge clk);
        bus.refill_start_i = 1'b1; bus.refill_addr_i = 6'd9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.refill_start_i = 1'b0;
            bus.beat_valid_i = 1'b1; bus.beat_data_i = beats[k];
            #1;
            checks++;
            if (bus.beat_ready_o !== 1'b1 || bus.ram_we_o !== 1'b0)
                $display("FAIL refill_beat%0d: beat_ready=%b we=%b want 1 0", k, bus.beat_ready_o, bus.ram_we_o);
            else passes++;
        end
        @(negedge clk);
        bus.beat_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o} !== {2'b11, 6'd9} || bus.ram_data_o !== exp_line)
            $display("FAIL refill_write: req/we/addr=%b/%b/%0d data=%h want 1/1/9 %h",
                     bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, exp_line);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.refill_done_o !== 1'b1 || wr_to[9] !== w9 + 1)
            $display("FAIL refill_done: done=%b writes_to_9=%0d want 1 %0d", bus.refill_done_o, wr_to[9], w9 + 1);
        else passes++;
        bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 6'd9;
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        checks++;
        if (bus.refill_done_o !== 1'b0 || bus.lookup_valid_o !== 1'b1 || bus.lookup_data_o !== exp_line)
            $display("FAIL refill_readback: done=%b valid=%b data=%h want 0 1 %h",
                     bus.refill_done_o, bus.lookup_valid_o, bus.lookup_data_o, exp_line);
        else passes++;
    endtask

    task automatic test_gaps_and_lookups();
        logic [BW-1:0] beats [4];
        logic [SW-1:0] exp_line;
        logic [SW-1:0] prev_exp;
        logic          prev_look;
        beats = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        exp_line = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
        prev_look = 1'b0;
        prev_exp = '0;
        @(negedge clk);
        bus.refill_start_i = 1'b1; bus.refill_addr_i = 6'd12;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.refill_start_i = 1'b0;
            if (prev_look) begin
                checks++;
                if (bus.lookup_valid_o !== 1'b1 || bus.lookup_data_o !== prev_exp)
                    $display("FAIL fill_lookup%0d: valid=%b data=%h want 1 %h", i,
                             bus.lookup_valid_o, bus.lookup_data_o, prev_exp);
                else passes++;
            end
            bus.beat_valid_i  = (i % 2 == 0);
            bus.beat_data_i   = beats[i / 2];
            bus.lookup_req_i  = (i <= 3) || (i == 5);
            bus.lookup_addr_i = (i == 5) ? 6'd12 : 6'd3;
            prev_look = bus.lookup_req_i;
            prev_exp  = (i == 5) ? LINE_C : LINE_B;
            #1;
            if (prev_look) begin
                checks++;
                if (bus.lookup_ready_o !== 1'b1 || bus.ram_we_o !== 1'b0)
                    $display("FAIL fill_ready%0d: ready=%b we=%b want 1 0", i, bus.lookup_ready_o, bus.ram_we_o);
                else passes++;
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if ({bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o} !== {2'b11, 6'd12} || bus.ram_data_o !== exp_line)
            $display("FAIL gap_write: req/we/addr=%b/%b/%0d data=%h want 1/1/12 %h",
                     bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, exp_line);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.refill_done_o !== 1'b1)
            $display("FAIL gap_done: done=%b want 1", bus.refill_done_o);
        else passes++;
    endtask

    task automatic test_flush_in_fill();
        int w20, wt, bad;
        logic [AW-1:0] addrs [3];
        addrs = '{6'd5, 6'd9, 6'd20};
        w20 = wr_to[20];
        wt  = wr_total;
        bad = 0;
        @(negedge clk);
        bus.refill_start_i = 1'b1; bus.refill_addr_i = 6'd20;
        @(negedge clk);
        bus.refill_start_i = 1'b0;
        bus.beat_valid_i = 1'b1; bus.beat_data_i = 64'h77;
        @(negedge clk);
        bus.beat_data_i = 64'h88; bus.flush_i = 1'b1;
        bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 6'd5;
        #1;
        checks++;
        if (bus.lookup_ready_o !== 1'b0 || bus.ram_req_o !== 1'b0)
            $display("FAIL flushfill_block: ready=%b req=%b want 0 0", bus.lookup_ready_o, bus.ram_req_o);
        else passes++;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            bus.flush_i = 1'b0; bus.beat_valid_i = 1'b0;
            #1;
            if (!(bus.flush_busy_o === 1'b1 && bus.lookup_ready_o === 1'b0 && bus.lookup_valid_o === 1'b0 &&
                  bus.ram_req_o === 1'b1 && bus.ram_we_o === 1'b1 && bus.ram_addr_o === AW'(k) &&
                  bus.ram_data_o === '0))
                bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL flush_sweep: %0d bad sweep cycles, want 0", bad);
        else passes++;
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        #1;
        checks++;
        if (bus.flush_busy_o !== 1'b0 || bus.lookup_ready_o !== 1'b1)
            $display("FAIL flush_end: busy=%b ready=%b want 0 1", bus.flush_busy_o, bus.lookup_ready_o);
        else passes++;
        checks++;
        if (wr_total !== wt + DEPTH || wr_to[20] !== w20 + 1)
            $display("FAIL flush_writes: total=%0d to20=%0d want %0d %0d", wr_total, wr_to[20], wt + DEPTH, w20 + 1);
        else passes++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.lookup_req_i = 1'b1; bus.lookup_addr_i = addrs[j];
            @(negedge clk);
            bus.lookup_req_i = 1'b0;
            checks++;
            if (bus.lookup_valid_o !== 1'b1 || bus.lookup_data_o !== '0)
                $display("FAIL flush_zero%0d: valid=%b data=%h want 1 0", addrs[j], bus.lookup_valid_o, bus.lookup_data_o);
            else passes++;
        end
    endtask

    task automatic test_flush_priority();
        int busy_n, w33, w30;
        logic [SW-1:0] exp_line;
        exp_line = {64'h4, 64'h3, 64'h2, 64'h1};
        w33 = wr_to[33];
        busy_n = 0;
        @(negedge clk);
        bus.refill_start_i = 1'b1; bus.refill_addr_i = 6'd33; bus.flush_i = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            bus.refill_start_i = 1'b0; bus.flush_i = 1'b0;
            #1;
            if (bus.flush_busy_o === 1'b1) busy_n++;
        end
        checks++;
        if (busy_n !== DEPTH || bus.beat_ready_o !== 1'b0 || wr_to[33] !== w33 + 1)
            $display("FAIL flush_wins: busy_cycles=%0d beat_ready=%b to33=%0d want %0d 0 %0d",
                     busy_n, bus.beat_ready_o, wr_to[33], DEPTH, w33 + 1);
        else passes++;
        // flush raised during WRITE: line still written, sweep follows
        w30 = wr_to[30];
        busy_n = 0;
        @(negedge clk);
        bus.refill_start_i = 1'b1; bus.refill_addr_i = 6'd30;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.refill_start_i = 1'b0;
            bus.beat_valid_i = 1'b1; bus.beat_data_i = BW'(k + 1);
        end
        @(negedge clk);
        bus.beat_valid_i = 1'b0; bus.flush_i = 1'b1;
        #1;
        checks++;
        if ({bus.ram_we_o, bus.ram_addr_o} !== {1'b1, 6'd30} || bus.ram_data_o !== exp_line)
            $display("FAIL write_then_flush_wr: we/addr=%b/%0d data=%h want 1/30 %h",
                     bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, exp_line);
        else passes++;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        checks++;
        if ({bus.refill_done_o, bus.flush_busy_o, bus.ram_addr_o} !== {2'b11, 6'd0})
            $display("FAIL write_then_flush_start: done/busy/addr=%b/%b/%0d want 1/1/0",
                     bus.refill_done_o, bus.flush_busy_o, bus.ram_addr_o);
        else passes++;
        for (int k = 0; k < 70; k++) begin
            if (bus.flush_busy_o === 1'b1) busy_n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (busy_n !== DEPTH || wr_to[30] !== w30 + 2)
            $display("FAIL write_then_flush_end: busy_cycles=%0d to30=%0d want %0d %0d",
                     busy_n, wr_to[30], DEPTH, w30 + 2);
        else passes++;
    endtask

    task automatic test_reset_midway();
        int wt, done_n, busy_n;
        // reset in FILL
        done_n = 0;
        @(negedge clk);
        bus.refill_start_i = 1'b1; bus.refill_addr_i = 6'd40;
        @(negedge clk);
        bus.refill_start_i = 1'b0; bus.beat_valid_i = 1'b1; bus.beat_data_i = 64'h99;
        @(negedge clk);
        rst = 1'b1; bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 6'd3;
        #1;
        wt = wr_total;
        checks++;
        if (outs_any() !== 1'b0) $display("FAIL rst_fill_outs: output nonzero in reset, want all 0");
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; drive_idle();
        #1;
        checks++;
        if (bus.beat_ready_o !== 1'b0 || bus.lookup_ready_o !== 1'b1)
            $display("FAIL rst_fill_idle: beat_ready=%b ready=%b want 0 1", bus.beat_ready_o, bus.lookup_ready_o);
        else passes++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (bus.refill_done_o === 1'b1) done_n++;
        end
        checks++;
        if (done_n !== 0 || wr_total !== wt)
            $display("FAIL rst_fill_nowrite: done_pulses=%0d writes=%0d want 0 %0d", done_n, wr_total, wt);
        else passes++;
        // reset in FLUSH
        busy_n = 0;
        @(negedge clk);
        bus.flush_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.flush_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        wt = wr_total;
        checks++;
        if (outs_any() !== 1'b0) $display("FAIL rst_flush_outs: output nonzero in reset, want all 0");
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.flush_busy_o === 1'b1 || bus.ram_req_o === 1'b1) busy_n++;
            @(negedge clk);
        end
        checks++;
        if (busy_n !== 0 || wr_total !== wt)
            $display("FAIL rst_flush_idle: busy_or_req_cycles=%0d writes=%0d want 0 %0d", busy_n, wr_total, wt);
        else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_lookup();
        test_refill();
        test_gaps_and_lookups();
        test_flush_in_fill();
        test_flush_priority();
        test_reset_midway();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
